// File: rtl/alu181_seq.sv
// Multi-cycle WIDTH-bit ALU built from one 74181-style 4-bit slice per clock,
// LSB slice first, with the slice carry held in a register between cycles.
module alu181_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn_b,
    input  logic             acc_sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] f,
    output logic             cn4_b,
    output logic             aeb,
    output logic [WIDTH-1:0] acc
);

    localparam int SLICES = WIDTH / 4;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] work;
    logic [3:0]       s_r;
    logic             m_r;
    logic             carry_b;
    logic [IW-1:0]    idx;

    logic [IW+1:0]    base;
    logic [3:0]       slice_f;
    logic             slice_cout_b;
    logic [WIDTH-1:0] result;

    // One 74181 slice; returns {cout_b, f[3:0]}. g/p are the active-high
    // generate/propagate derived from E and D (g implies p since both contain A).
    function automatic logic [4:0] slice181(
        input logic [3:0] av,
        input logic [3:0] bv,
        input logic [3:0] sv,
        input logic       mv,
        input logic       cin_b
    );
        logic [3:0] e;
        logic [3:0] d;
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic [3:0] fv;
        logic       y;
        logic       cout_b;
        e = ~((av & bv & {4{sv[3]}}) | (av & ~bv & {4{sv[2]}}));
        d = ~((~bv & {4{sv[1]}}) | (bv & {4{sv[0]}}) | av);
        g = ~e;
        p = ~d;
        c[0] = ~cin_b;
        c[1] = g[0] | (p[0] & c[0]);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        y = ~(d[3] | (d[2] & e[3]) | (d[1] & e[2] & e[3]) | (d[0] & e[1] & e[2] & e[3]));
        cout_b = ~(y & ~((&e) & cin_b));
        fv = e ^ d ^ (c | {4{mv}});
        return {cout_b, fv};
    endfunction

    assign base = {idx, 2'b00};

    always_comb begin
        {slice_cout_b, slice_f} = slice181(opa[base +: 4], opb[base +: 4], s_r, m_r, carry_b);
        result = work;
        result[base +: 4] = slice_f;
    end

    // Operands are captured only on the accepting edge, so a/b/s/m/cn_b
    // may change freely while an operation is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            opa     <= '0;
            opb     <= '0;
            work    <= '0;
            s_r     <= '0;
            m_r     <= 1'b0;
            carry_b <= 1'b1;
            idx     <= '0;
            f       <= '0;
            acc     <= '0;
            cn4_b   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa     <= acc_sel ? acc : a;
                        opb     <= b;
                        s_r     <= s;
                        m_r     <= m;
                        carry_b <= cn_b;
                        idx     <= '0;
                        work    <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    work    <= result;
                    carry_b <= slice_cout_b;
                    idx     <= idx + IW'(1);
                    if (idx == IW'(SLICES - 1)) begin
                        f     <= result;
                        acc   <= result;
                        cn4_b <= slice_cout_b;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign aeb  = &f;

endmodule

// File: tb/tb_alu181_seq.sv
// Directed bench for alu181_seq: 16-bit core plus 4-bit and 32-bit builds,
// hand-computed 74181 results, handshake timing, reset and held-start behaviour.
module tb_alu181_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start4, start16, start32;
    logic [3:0]  s;
    logic        m, cn_b, acc_sel;
    logic [31:0] a, b;

    logic        busy4, done4, cn4_b4, aeb4;
    logic [3:0]  f4, acc4;
    logic        busy16, done16, cn4_b16, aeb16;
    logic [15:0] f16, acc16;
    logic        busy32, done32, cn4_b32, aeb32;
    logic [31:0] f32, acc32;

    int          cur_w;
    logic        busy_w, done_w, cn4_w, aeb_w;
    logic [31:0] f_w, acc_w;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    alu181_seq #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .s(s), .m(m), .cn_b(cn_b),
        .acc_sel(acc_sel), .a(a[3:0]), .b(b[3:0]), .busy(busy4), .done(done4),
        .f(f4), .cn4_b(cn4_b4), .aeb(aeb4), .acc(acc4)
    );

    alu181_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .s(s), .m(m), .cn_b(cn_b),
        .acc_sel(acc_sel), .a(a[15:0]), .b(b[15:0]), .busy(busy16), .done(done16),
        .f(f16), .cn4_b(cn4_b16), .aeb(aeb16), .acc(acc16)
    );

    alu181_seq #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .start(start32), .s(s), .m(m), .cn_b(cn_b),
        .acc_sel(acc_sel), .a(a), .b(b), .busy(busy32), .done(done32),
        .f(f32), .cn4_b(cn4_b32), .aeb(aeb32), .acc(acc32)
    );

    always_comb begin
        busy_w = busy16;
        done_w = done16;
        cn4_w  = cn4_b16;
        aeb_w  = aeb16;
        f_w    = {16'h0, f16};
        acc_w  = {16'h0, acc16};
        case (cur_w)
            4: begin
                busy_w = busy4;  done_w = done4;  cn4_w = cn4_b4;  aeb_w = aeb4;
                f_w = {28'h0, f4};  acc_w = {28'h0, acc4};
            end
            32: begin
                busy_w = busy32; done_w = done32; cn4_w = cn4_b32; aeb_w = aeb32;
                f_w = f32;  acc_w = acc32;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation on the selected instance, scrambles every input
    // while it runs, and returns the outputs sampled in the DONE cycle.
    task automatic run_op(input int w, input logic [3:0] s_v, input logic m_v,
                          input logic cn_v, input logic acc_v,
                          input logic [31:0] a_v, input logic [31:0] b_v,
                          output logic [31:0] f_o, output logic [31:0] acc_o,
                          output logic cn4_o, output logic aeb_o);
        int cyc;
        int busy_n;
        @(negedge clk);
        cur_w = w;
        s = s_v; m = m_v; cn_b = cn_v; acc_sel = acc_v; a = a_v; b = b_v;
        case (w)
            4:       start4 = 1'b1;
            32:      start32 = 1'b1;
            default: start16 = 1'b1;
        endcase
        @(negedge clk);
        start4 = 1'b0; start16 = 1'b0; start32 = 1'b0;
        cyc = 0;
        busy_n = 0;
        while (!done_w && cyc < 40) begin
            if (busy_w) busy_n++;
            a = $urandom; b = $urandom;
            s = 4'($urandom_range(0, 15));
            m = 1'($urandom_range(0, 1));
            cn_b = 1'($urandom_range(0, 1));
            acc_sel = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, w / 4);
        check("busy_cycles", busy_n, w / 4);
        check("busy_in_done", busy_w, 0);
        f_o = f_w; acc_o = acc_w; cn4_o = cn4_w; aeb_o = aeb_w;
        @(negedge clk);
        check("done_one_cycle", done_w, 0);
    endtask

    logic [31:0] r_f, r_acc;
    logic        r_cn4, r_aeb;
    int          n_done, n_busy, first_done, last_done;

    initial begin
        rst = 1'b1;
        start4 = 1'b0; start16 = 1'b0; start32 = 1'b0;
        s = '0; m = 1'b0; cn_b = 1'b1; acc_sel = 1'b0; a = '0; b = '0;
        cur_w = 16;
        repeat (2) @(negedge clk);
        check("rst_busy", busy16, 0);
        check("rst_done", done16, 0);
        check("rst_f", f16, 16'h0);
        check("rst_acc", acc16, 16'h0);
        check("rst_cn4", cn4_b16, 1);
        check("rst_aeb", aeb16, 0);
        rst = 1'b0;

        run_op(16, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h1234, 32'h4321, r_f, r_acc, r_cn4, r_aeb);
        check("add_f", r_f, 32'h5555);
        check("add_cn4", r_cn4, 1);
        check("add_acc", r_acc, 32'h5555);

        run_op(16, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hFFFF, 32'h0001, r_f, r_acc, r_cn4, r_aeb);
        check("ripple_f", r_f, 32'h0000);
        check("ripple_cn4", r_cn4, 0);
        check("ripple_aeb", r_aeb, 0);

        run_op(16, 4'b0110, 1'b0, 1'b1, 1'b0, 32'hA5A5, 32'hA5A5, r_f, r_acc, r_cn4, r_aeb);
        check("cmp_eq_f", r_f, 32'hFFFF);
        check("cmp_eq_aeb", r_aeb, 1);
        check("cmp_eq_cn4", r_cn4, 1);

        run_op(16, 4'b0110, 1'b0, 1'b1, 1'b0, 32'hA5A5, 32'hA5A4, r_f, r_acc, r_cn4, r_aeb);
        check("cmp_ne_f", r_f, 32'h0000);
        check("cmp_ne_aeb", r_aeb, 0);
        check("cmp_ne_cn4", r_cn4, 0);

        run_op(16, 4'b1011, 1'b1, 1'b1, 1'b0, 32'hF0F0, 32'h3C3C, r_f, r_acc, r_cn4, r_aeb);
        check("and_f", r_f, 32'h3030);
        check("and_acc", r_acc, 32'h3030);
        check("and_logic_cn4", r_cn4, 0);

        run_op(16, 4'b1001, 1'b0, 1'b1, 1'b1, 32'hDEAD, 32'h0001, r_f, r_acc, r_cn4, r_aeb);
        check("accfb_f", r_f, 32'h3031);
        check("accfb_acc", r_acc, 32'h3031);
        check("accfb_cn4", r_cn4, 1);

        run_op(16, 4'b0000, 1'b1, 1'b1, 1'b0, 32'h0F0F, 32'h0000, r_f, r_acc, r_cn4, r_aeb);
        check("nota_f", r_f, 32'hF0F0);
        check("nota_cn4", r_cn4, 1);

        run_op(16, 4'b1001, 1'b0, 1'b0, 1'b0, 32'h00FF, 32'h0000, r_f, r_acc, r_cn4, r_aeb);
        check("cin_f", r_f, 32'h0100);
        check("cin_cn4", r_cn4, 1);
        check("hold_f", f16, 16'h0100);

        // Reset two RUN cycles into an operation.
        @(negedge clk);
        a = 32'h1111; b = 32'h2222; s = 4'b1001; m = 1'b0; cn_b = 1'b1; acc_sel = 1'b0;
        start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy16, 0);
        check("midrst_done", done16, 0);
        check("midrst_f", f16, 16'h0);
        check("midrst_acc", acc16, 16'h0);
        check("midrst_cn4", cn4_b16, 1);
        check("midrst_aeb", aeb16, 0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done16) n_done++;
            if (busy16) n_busy++;
        end
        check("postrst_no_done", n_done, 0);
        check("postrst_no_busy", n_busy, 0);

        // start held high: one op every SLICES+2 cycles.
        a = 32'h0001; b = 32'h0002; s = 4'b1001; m = 1'b0; cn_b = 1'b1; acc_sel = 1'b0;
        start16 = 1'b1;
        n_done = 0;
        first_done = 0;
        last_done = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done16) begin
                n_done++;
                if (first_done == 0) first_done = i;
                last_done = i;
                check("held_f", f16, 16'h0003);
            end
        end
        start16 = 1'b0;
        check("held_done_count", n_done, 2);
        check("held_first_done", first_done, 5);
        check("held_period", last_done - first_done, 6);
        repeat (2) @(negedge clk);
        check("held_idle", busy16, 0);

        run_op(4, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h7, 32'h9, r_f, r_acc, r_cn4, r_aeb);
        check("w4_f", r_f, 32'h0);
        check("w4_cn4", r_cn4, 0);
        check("w4_acc", r_acc, 32'h0);

        run_op(32, 4'b1001, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 32'h1, r_f, r_acc, r_cn4, r_aeb);
        check("w32_f", r_f, 32'h0);
        check("w32_cn4", r_cn4, 0);

        run_op(32, 4'b1001, 1'b0, 1'b1, 1'b0, 32'h12345678, 32'h0FEDCBA8, r_f, r_acc, r_cn4, r_aeb);
        check("w32_sum_f", r_f, 32'h22222220);
        check("w32_sum_cn4", r_cn4, 1);
        check("w32_sum_acc", r_acc, 32'h22222220);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
